mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Opcode  input  6  instruction opcode field from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 MemReady  input  1  memory handshake; access completes in the cycle it is sampled 1.
REQ-007 PCEn  output  1  PC register write enable.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemRead  output  1  memory read strobe.
REQ-010 MemWrite  output  1  memory write strobe.
REQ-011 IRWrite  output  1  instruction register load.
REQ-012 MemtoReg  output  1  register write data select: 0 = ALUOut, 1 = MDR.
REQ-013 RegDst  output  1  destination register select: 0 = rt, 1 = rd.
REQ-014 RegWrite  output  1  register file write enable.
REQ-015 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = shifted imm.
REQ-017 ALUOp  output  2  ALU operation class: 00 = add, 01 = subtract, 10 = decode funct.
REQ-018 PCSource  output  2  select of the 3:1 next-PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-019 Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-020 InstrCount  output  CNT_W  count of retired instructions.

Function
REQ-021 The block SHALL be a Moore FSM with the states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BRANCH, ADDIEX, ADDIWB and JUMP, held in a 4-bit register.
REQ-022 Transitions SHALL be: IDLE->FETCH; FETCH->DECODE; DECODE->(lw 100011 or sw 101011)MEMADR, (000000)RTEXEC, (beq 000100)BRANCH, (addi 001000)ADDIEX, (j 000010)JUMP, any other opcode->FETCH; MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; RTEXEC->RTWB; ADDIEX->ADDIWB; and MEMWB, MEMWR, RTWB, ADDIWB, BRANCH and JUMP->FETCH.
REQ-023 FETCH, MEMRD and MEMWR SHALL hold state while MemReady=0 and SHALL advance in the cycle MemReady=1, with strobes held constant while waiting.
REQ-024 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; IRWrite=1 and PCEn=1 SHALL be asserted only in the cycle MemReady=1.
REQ-025 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00.
REQ-026 Memory and ALU states SHALL drive the following: MEMADR ALUSrcA=1, ALUSrcB=10, ALUOp=00; MEMRD MemRead=1, IorD=1; MEMWR MemWrite=1, IorD=1; MEMWB RegWrite=1, MemtoReg=1, RegDst=0.
REQ-027 Register-writing states SHALL drive the following: RTEXEC ALUSrcA=1, ALUSrcB=00, ALUOp=10; RTWB RegWrite=1, RegDst=1, MemtoReg=0; ADDIEX ALUSrcA=1, ALUSrcB=10, ALUOp=00; ADDIWB RegWrite=1, RegDst=0, MemtoReg=0.
REQ-028 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01 and PCEn=Zero (combinational from Zero); JUMP SHALL drive PCSource=10 and PCEn=1.
REQ-029 Every output not listed for a state SHALL be 0, and PCSource SHALL never be 11.
REQ-030 Illegal SHALL be registered, pulsing high for exactly one cycle, the cycle after DECODE sees an unsupported opcode.
REQ-031 InstrCount SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, ADDIWB, BRANCH or JUMP, wrapping from 2^CNT_W-1 to 0; illegal opcodes SHALL NOT count.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, InstrCount=0 and Illegal=0, and all strobe and select outputs SHALL be 0 while in IDLE.
REQ-033 Reset asserted mid-instruction SHALL abandon the instruction with no further MemWrite, RegWrite or PCEn; after rst_n deasserts, FETCH SHALL follow exactly one IDLE cycle.

Structure
REQ-034 The state encodings, opcode constants, ALUSrcB/ALUOp/PCSource codes and the CNT_W default SHALL reside in the shared package mips_ctrl_pkg.
REQ-035 The state-to-output decode SHALL be a single combinational sub-module, mips_ctrl_decode; the state register, counter and Illegal flop SHALL stay in the top-level module.

Verification
REQ-036 The bench SHALL drive lw (100011) with MemReady=1 and check the sequence IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH (5 cycles per instruction), RegWrite=1 with MemtoReg=1 in MEMWB, and InstrCount 0->1.
REQ-037 The bench SHALL drive sw with MemReady=0 for 3 cycles in MEMWR and check MemWrite=1 held for 4 cycles, RegWrite=0 throughout, and a single count.
REQ-038 The bench SHALL drive beq with Zero=1 and then Zero=0 and check PCSource=01 in both cases, with PCEn=1 only when Zero=1.
REQ-039 The bench SHALL drive j (000010) and check PCSource=10 with PCEn=1 for one cycle, then opcode 111111 and check an Illegal pulse, return to FETCH, and an unchanged InstrCount.
REQ-040 The bench SHALL preload InstrCount to 2^CNT_W-1 via 2^CNT_W-1 retirements with CNT_W=4 and check that the next retirement wraps it to 0.
REQ-041 The bench SHALL assert rst_n=0 in RTWB and check that RegWrite drops asynchronously, all outputs are 0, and the sequence restarts IDLE->FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// mux/ALU select codes and the bundled control-word struct.
package mips_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXEC = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// State-to-control-word decode. Pure combinational; only FETCH (MemReady)
// and BRANCH (Zero) look past the state itself.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   memready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                // IR and PC only commit in the cycle the memory returns data
                ctrl.irwrite  = memready;
                ctrl.pcen     = memready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_SHIMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_RTEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_RT;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
                ctrl.pcen     = zero;
            end
            S_JUMP: begin
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.pcen     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, retired-instruction counter
// and illegal-opcode flag; control strobes come from mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    state_t state;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            InstrCount <= '0;
            Illegal    <= 1'b0;
        end else begin
            Illegal <= 1'b0;
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_RTEXEC;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default: begin
                            state   <= S_FETCH;
                            Illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state <= (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (MemReady) state <= S_MEMWB;
                S_RTEXEC: state <= S_RTWB;
                S_ADDIEX: state <= S_ADDIWB;
                S_MEMWR: begin
                    if (MemReady) begin
                        state      <= S_FETCH;
                        InstrCount <= InstrCount + CNT_W'(1);
                    end
                end
                // final state of every legal instruction retires it
                S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                    state      <= S_FETCH;
                    InstrCount <= InstrCount + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mips_ctrl_decode u_decode (
        .state    (state),
        .memready (MemReady),
        .zero     (Zero),
        .ctrl     (ctrl)
    );

    assign PCEn     = ctrl.pcen;
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.memread;
    assign MemWrite = ctrl.memwrite;
    assign IRWrite  = ctrl.irwrite;
    assign MemtoReg = ctrl.memtoreg;
    assign RegDst   = ctrl.regdst;
    assign RegWrite = ctrl.regwrite;
    assign ALUSrcA  = ctrl.alusrca;
    assign ALUSrcB  = ctrl.alusrcb;
    assign ALUOp    = ctrl.aluop;
    assign PCSource = ctrl.pcsource;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: the driver queues the expected control word for every
// cycle it drives; the monitor pops and compares on the falling edge.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    Opcode = '0;
    logic          Zero = 1'b0;
    logic          MemReady = 1'b0;
    logic          PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSource;
    logic          Illegal;
    logic [CW-1:0] InstrCount;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Illegal(Illegal), .InstrCount(InstrCount)
    );

    typedef enum {T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                  T_RTEXEC, T_RTWB, T_BRANCH, T_ADDIEX, T_ADDIWB, T_JUMP} tst_e;
    typedef struct {
        string       name;
        logic [19:0] exp;
    } sb_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    sb_t           sbq[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_cnt = '0;
    event          chk_ev;

    wire [19:0] act = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, InstrCount};

    // Expected control word per state, straight from the output table
    function automatic logic [19:0] model(tst_e s, logic mr, logic z, logic ill, logic [CW-1:0] c);
        logic pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aop, pcs;
        {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            T_FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
            T_DECODE: srcb = 2'b11;
            T_MEMADR, T_ADDIEX: begin srca = 1; srcb = 2'b10; end
            T_MEMRD:  begin mrd = 1; iord = 1; end
            T_MEMWR:  begin mwr = 1; iord = 1; end
            T_MEMWB:  begin rw = 1; m2r = 1; end
            T_RTEXEC: begin srca = 1; aop = 2'b10; end
            T_RTWB:   begin rw = 1; rdst = 1; end
            T_ADDIWB: rw = 1;
            T_BRANCH: begin srca = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            T_JUMP:   begin pcs = 2'b10; pcen = 1; end
            default:  ;
        endcase
        return {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs, ill, c};
    endfunction

    always begin : monitor
        sb_t e;
        @(negedge clk or chk_ev);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s act=%h exp=%h", e.name, act, e.exp);
            end
        end
    end

    // Called at posedge+1: drives one cycle and queues its expected word
    task automatic step(string tag, tst_e s, logic [5:0] op, logic mr, logic z, logic ill, logic ret);
        Opcode = op; MemReady = mr; Zero = z;
        sbq.push_back('{name: $sformatf("%s_%s", tag, s.name()), exp: model(s, mr, z, ill, exp_cnt)});
        @(posedge clk); #1;
        if (ret) exp_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        step("rst", T_IDLE, RT, 0, 0, 0, 0);
        step("rst", T_IDLE, RT, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("boot", T_IDLE, RT, 0, 0, 0, 0);

        // lw, memory always ready
        step("lw", T_FETCH, LW, 1, 0, 0, 0);
        step("lw", T_DECODE, LW, 1, 0, 0, 0);
        step("lw", T_MEMADR, LW, 1, 0, 0, 0);
        step("lw", T_MEMRD, LW, 1, 0, 0, 0);
        step("lw", T_MEMWB, LW, 1, 0, 0, 1);

        // sw with three wait cycles in MEMWR
        step("sw", T_FETCH, SW, 1, 0, 0, 0);
        step("sw", T_DECODE, SW, 1, 0, 0, 0);
        step("sw", T_MEMADR, SW, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("swwait", T_MEMWR, SW, 0, 0, 0, 0);
        step("sw", T_MEMWR, SW, 1, 0, 0, 1);

        // beq taken, then not taken with a fetch stall
        step("beq1", T_FETCH, BEQ, 1, 1, 0, 0);
        step("beq1", T_DECODE, BEQ, 1, 1, 0, 0);
        step("beq1", T_BRANCH, BEQ, 1, 1, 0, 1);
        step("beq0stall", T_FETCH, BEQ, 0, 0, 0, 0);
        step("beq0", T_FETCH, BEQ, 1, 0, 0, 0);
        step("beq0", T_DECODE, BEQ, 1, 0, 0, 0);
        step("beq0", T_BRANCH, BEQ, 1, 0, 0, 1);

        // jump, then an illegal opcode followed by addi
        step("j", T_FETCH, J, 1, 0, 0, 0);
        step("j", T_DECODE, J, 1, 0, 0, 0);
        step("j", T_JUMP, J, 1, 0, 0, 1);
        step("bad", T_FETCH, BAD, 1, 0, 0, 0);
        step("bad", T_DECODE, BAD, 1, 0, 0, 0);
        step("addi_ill", T_FETCH, ADDI, 1, 0, 1, 0);
        step("addi", T_DECODE, ADDI, 1, 0, 0, 0);
        step("addi", T_ADDIEX, ADDI, 1, 0, 0, 0);
        step("addi", T_ADDIWB, ADDI, 1, 0, 0, 1);

        // count 6 -> 15 -> wraps to 0
        for (int i = 0; i < 10; i++) begin
            step("jwrap", T_FETCH, J, 1, 0, 0, 0);
            step("jwrap", T_DECODE, J, 1, 0, 0, 0);
            step("jwrap", T_JUMP, J, 1, 0, 0, 1);
        end

        step("rt", T_FETCH, RT, 1, 0, 0, 0);
        step("rt", T_DECODE, RT, 1, 0, 0, 0);
        step("rt", T_RTEXEC, RT, 1, 0, 0, 0);
        step("rt", T_RTWB, RT, 1, 0, 0, 1);

        // second R-type, reset lands in the middle of RTWB
        step("rtrst", T_FETCH, RT, 1, 0, 0, 0);
        step("rtrst", T_DECODE, RT, 1, 0, 0, 0);
        step("rtrst", T_RTEXEC, RT, 1, 0, 0, 0);
        sbq.push_back('{name: "rtrst_T_RTWB", exp: model(T_RTWB, 1, 0, 0, exp_cnt)});
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        sbq.push_back('{name: "async_rst", exp: model(T_IDLE, 1, 0, 0, exp_cnt)});
        ->chk_ev;
        @(posedge clk); #1;
        step("inrst", T_IDLE, RT, 1, 0, 0, 0);
        rst_n = 1'b1;
        step("restart", T_IDLE, RT, 1, 0, 0, 0);
        step("restart", T_FETCH, LW, 1, 0, 0, 0);
        step("restart", T_DECODE, LW, 1, 0, 0, 0);

        @(negedge clk); #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
